// File: rtl/hh_tag_modulator_if.sv
// Handshake and RF-side signal bundle for the backscatter tag modulator.
interface hh_tag_modulator_if #(
  parameter int PAYLOAD_BITS = 16
);
  logic                    trigger_signal;
  logic [1:0]              mode;
  logic [PAYLOAD_BITS-1:0] payload;
  logic                    load_valid;
  logic                    load_ready;
  logic                    clock_out;
  logic                    output_signal;
  logic                    signal_into_switch;
  logic                    busy;
  logic                    done;

  modport master (
    output trigger_signal, mode, payload, load_valid,
    input  load_ready, clock_out, output_signal, signal_into_switch, busy, done
  );

  modport slave (
    input  trigger_signal, mode, payload, load_valid,
    output load_ready, clock_out, output_signal, signal_into_switch, busy, done
  );
endinterface

// File: rtl/hh_tag_modulator.sv
// Trigger-started backscatter modulator: preamble wait, then FSK carrier keyed by a latched payload.
// Outputs are registered and track the SEND cycle index directly; payload accepted only while IDLE.
module hh_tag_modulator #(
  parameter int SHIFT_DIV       = 2,
  parameter int BIT_CYCLES      = 10,
  parameter int PREAMBLE_CYCLES = 20,
  parameter int PAYLOAD_BITS    = 16
) (
  input logic               clock,
  input logic               reset,
  hh_tag_modulator_if.slave bus
);

  localparam int WAIT_W = (PREAMBLE_CYCLES > 1) ? $clog2(PREAMBLE_CYCLES) : 1;
  localparam int DIV_W  = (SHIFT_DIV > 1)       ? $clog2(SHIFT_DIV)       : 1;
  localparam int CYC_W  = (BIT_CYCLES > 1)      ? $clog2(BIT_CYCLES)      : 1;
  localparam int IDX_W  = (PAYLOAD_BITS > 1)    ? $clog2(PAYLOAD_BITS)    : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PREAMBLE_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SHIFT_DIV - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    sync3_q, sync3_d;
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic [1:0]              mode_q, mode_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    sclk_q, sclk_d;
  logic [CYC_W-1:0]        bit_cyc_q, bit_cyc_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic                    clock_out_q, clock_out_d;
  logic                    output_signal_q, output_signal_d;
  logic                    switch_q, switch_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    load_ready_q, load_ready_d;

  logic rise;
  logic load_fire;
  logic send_last;
  logic enter_send;

  assign rise       = sync2_q & ~sync3_q;
  assign load_fire  = bus.load_valid & load_ready_q;
  assign send_last  = (bit_idx_q == IDX_LAST) && (bit_cyc_q == CYC_LAST);
  assign enter_send = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      sync3_q         <= 1'b0;
      payload_q       <= '0;
      mode_q          <= '0;
      wait_cnt_q      <= '0;
      div_cnt_q       <= '0;
      sclk_q          <= 1'b0;
      bit_cyc_q       <= '0;
      bit_idx_q       <= '0;
      shreg_q         <= '0;
      clock_out_q     <= 1'b0;
      output_signal_q <= 1'b0;
      switch_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      load_ready_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      sync3_q         <= sync3_d;
      payload_q       <= payload_d;
      mode_q          <= mode_d;
      wait_cnt_q      <= wait_cnt_d;
      div_cnt_q       <= div_cnt_d;
      sclk_q          <= sclk_d;
      bit_cyc_q       <= bit_cyc_d;
      bit_idx_q       <= bit_idx_d;
      shreg_q         <= shreg_d;
      clock_out_q     <= clock_out_d;
      output_signal_q <= output_signal_d;
      switch_q        <= switch_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      load_ready_q    <= load_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rise)       state_d = ST_WAIT;
      ST_WAIT: if (enter_send) state_d = ST_SEND;
      ST_SEND: if (send_last)  state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Counters are updated toward the value for the upcoming cycle, so registered outputs need no extra stage.
  always_comb begin
    sync1_d    = bus.trigger_signal;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    payload_d  = payload_q;
    mode_d     = mode_q;
    wait_cnt_d = wait_cnt_q;
    div_cnt_d  = div_cnt_q;
    sclk_d     = sclk_q;
    bit_cyc_d  = bit_cyc_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;

    if (load_fire) begin
      payload_d = bus.payload;
    end

    if ((state_q == ST_IDLE) && rise) begin
      mode_d     = bus.mode;
      wait_cnt_d = '0;
    end

    if ((state_q == ST_WAIT) && !enter_send) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (enter_send) begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
      bit_cyc_d = '0;
      bit_idx_d = '0;
      shreg_d   = payload_q;
    end else if ((state_q == ST_SEND) && !send_last) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        sclk_d    = ~sclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (bit_cyc_q == CYC_LAST) begin
        bit_cyc_d = '0;
        bit_idx_d = bit_idx_q + 1'b1;
        shreg_d   = shreg_q << 1;
      end else begin
        bit_cyc_d = bit_cyc_q + 1'b1;
      end
    end
  end

  always_comb begin
    logic send_n;
    logic sclk_n;
    logic bit_n;
    send_n          = (state_d == ST_SEND);
    sclk_n          = send_n & sclk_d;
    bit_n           = send_n & shreg_d[PAYLOAD_BITS-1];
    clock_out_d     = sclk_n;
    output_signal_d = bit_n;
    case (mode_q)
      2'd0:    switch_d = sclk_n ^ bit_n;
      2'd1:    switch_d = sclk_n & bit_n;
      default: switch_d = sclk_n;
    endcase
    load_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  assign bus.load_ready         = load_ready_q;
  assign bus.clock_out          = clock_out_q;
  assign bus.output_signal      = output_signal_q;
  assign bus.signal_into_switch = switch_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

endmodule

// File: tb/tb_hh_tag_modulator.sv
// Bench for hh_tag_modulator: two instances (SHIFT_DIV 2 and 1) compared per cycle with a timeline model.
module tb_hh_tag_modulator;

  localparam int P  = 8;
  localparam int BC = 4;
  localparam int PB = 8;
  localparam int N  = PB * BC;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [5:0] cap [0:127];
  int tr_s [3];
  int tr_e [3];

  hh_tag_modulator_if #(.PAYLOAD_BITS(PB)) ia ();
  hh_tag_modulator_if #(.PAYLOAD_BITS(PB)) ib ();

  hh_tag_modulator #(.SHIFT_DIV(2), .BIT_CYCLES(BC), .PREAMBLE_CYCLES(P), .PAYLOAD_BITS(PB))
    u_a (.clock(clock), .reset(reset), .bus(ia));
  hh_tag_modulator #(.SHIFT_DIV(1), .BIT_CYCLES(BC), .PREAMBLE_CYCLES(P), .PAYLOAD_BITS(PB))
    u_b (.clock(clock), .reset(reset), .bus(ib));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {load_ready, busy, done, clock_out, output_signal, switch} after edge k0+j... given rise at k0.
  function automatic logic [5:0] model(input int j, input int k0, input logic [7:0] p,
                                       input logic [1:0] m, input int sd);
    int rel;
    int i;
    logic s;
    logic b;
    logic w;
    rel = j - k0;
    if (rel >= 2 && rel < 2 + P) return 6'b010000;
    if (rel >= 2 + P && rel < 2 + P + N) begin
      i = rel - 2 - P;
      s = ((i / sd) % 2) == 1;
      b = p[PB - 1 - i / BC];
      if (m == 2'd0)      w = s ^ b;
      else if (m == 2'd1) w = s & b;
      else                w = s;
      return {1'b0, 1'b1, 1'b0, s, b, w};
    end
    if (rel == 2 + P + N) return 6'b011000;
    return 6'b100000;
  endfunction

  function automatic logic trig_at(input int j);
    for (int q = 0; q < 3; q++) if (j >= tr_s[q] && j < tr_e[q]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] sample(input int sel);
    if (sel == 0)
      return {ia.load_ready, ia.busy, ia.done, ia.clock_out, ia.output_signal, ia.signal_into_switch};
    return {ib.load_ready, ib.busy, ib.done, ib.clock_out, ib.output_signal, ib.signal_into_switch};
  endfunction

  task automatic drive(input int sel, input logic t, input logic lv, input logic [7:0] pl,
                       input logic [1:0] md);
    if (sel == 0) begin
      ia.trigger_signal = t; ia.load_valid = lv; ia.payload = pl; ia.mode = md;
    end else begin
      ib.trigger_signal = t; ib.load_valid = lv; ib.payload = pl; ib.mode = md;
    end
  endtask

  task automatic idle(input int n);
    drive(0, 1'b0, 1'b0, 8'h00, 2'd0);
    drive(1, 1'b0, 1'b0, 8'h00, 2'd0);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_trig(input int a0, input int a1, input int b0, input int b1,
                          input int c0, input int c1);
    tr_s[0] = a0; tr_e[0] = a1; tr_s[1] = b0; tr_e[1] = b1; tr_s[2] = c0; tr_e[2] = c1;
  endtask

  task automatic load_word(input logic [7:0] w);
    ia.load_valid = 1'b1; ia.payload = w;
    @(negedge clock);
    ia.load_valid = 1'b0;
    @(negedge clock);
  endtask

  // cap[j] holds outputs after edge k+j; edge k is the first edge sampling the trigger high.
  task automatic capture(input int sel, input int ncap, input int ld_at, input logic [7:0] ld_val,
                         input logic [1:0] md);
    logic [1:0] mn;
    drive(sel, trig_at(0), ld_at == 0, (ld_at == 0) ? ld_val : 8'($urandom), md);
    @(posedge clock);
    for (int j = 0; j < ncap; j++) begin
      @(negedge clock);
      cap[j] = sample(sel);
      mn = (j + 1 >= 3 && j + 1 < 40) ? 2'($urandom) : md;
      drive(sel, trig_at(j + 1), (j + 1) == ld_at,
            ((j + 1) == ld_at) ? ld_val : 8'($urandom), mn);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (sample(0) !== 6'b100000) begin errors++; $display("FAIL reset_a got %b exp %b", sample(0), 6'b100000); end
    checks++; if (sample(1) !== 6'b100000) begin errors++; $display("FAIL reset_b got %b exp %b", sample(1), 6'b100000); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (sample(0) !== 6'b100000) begin errors++; $display("FAIL post_reset_a got %b exp %b", sample(0), 6'b100000); end
  endtask

  task automatic test_phase_flip();
    logic [3:0] sw;
    logic [7:0] bits;
    logic [5:0] exp;
    idle(4);
    set_trig(0, 3, -1, -1, -1, -1);
    capture(0, 50, 2, 8'hA5, 2'd0);
    for (int j = 0; j < 50; j++) begin
      exp = model(j, 0, 8'hA5, 2'd0, 2);
      checks++;
      if (cap[j] !== exp) begin errors++; $display("FAIL phase_flip j=%0d got %b exp %b", j, cap[j], exp); end
    end
    for (int i = 0; i < 4; i++) sw[3 - i] = cap[10 + i][0];
    checks++; if (sw !== 4'b1100) begin errors++; $display("FAIL pf_switch_0_3 got %b exp 1100", sw); end
    for (int b = 0; b < 8; b++) bits[7 - b] = cap[10 + 4 * b][1];
    checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL pf_bits got %h exp a5", bits); end
    checks++;
    if ({cap[41][3], cap[42][3], cap[43][3]} !== 3'b010) begin
      errors++; $display("FAIL pf_done got %b exp 010", {cap[41][3], cap[42][3], cap[43][3]});
    end
  endtask

  task automatic test_ook();
    logic [5:0] exp;
    logic ok;
    idle(4);
    set_trig(0, 3, -1, -1, -1, -1);
    capture(0, 46, 0, 8'h0F, 2'd1);
    for (int j = 0; j < 46; j++) begin
      exp = model(j, 0, 8'h0F, 2'd1, 2);
      checks++;
      if (cap[j] !== exp) begin errors++; $display("FAIL ook j=%0d got %b exp %b", j, cap[j], exp); end
    end
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (cap[10 + i][0] !== ((i < 16) ? 1'b0 : cap[10 + i][2])) ok = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ook_gate got %b exp 1", ok); end
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic [1:0] m;
    int la;
    int tl;
    logic [5:0] exp;
    for (int n = 0; n < 4; n++) begin
      p  = 8'($urandom);
      m  = 2'($urandom);
      la = $urandom_range(0, 2);
      tl = $urandom_range(1, 40);
      idle(4);
      set_trig(0, tl, -1, -1, -1, -1);
      capture(0, 46, la, p, m);
      for (int j = 0; j < 46; j++) begin
        exp = model(j, 0, p, m, 2);
        checks++;
        if (cap[j] !== exp) begin errors++; $display("FAIL random n=%0d j=%0d got %b exp %b", n, j, cap[j], exp); end
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [5:0] exp;
    int dn;
    idle(4);
    load_word(8'hA5);
    set_trig(0, 20, 22, 100, -1, -1);
    capture(0, 110, 5, 8'hFF, 2'd0);
    dn = 0;
    for (int j = 0; j < 110; j++) begin
      exp = model(j, 0, 8'hA5, 2'd0, 2);
      dn += int'(cap[j][3]);
      checks++;
      if (cap[j] !== exp) begin errors++; $display("FAIL ignore_busy j=%0d got %b exp %b", j, cap[j], exp); end
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", dn); end
  endtask

  task automatic test_reset_abort();
    logic [5:0] exp;
    idle(4);
    drive(0, 1'b1, 1'b0, 8'h00, 2'd0);
    @(posedge clock);
    for (int j = 0; j < 18; j++) begin
      @(negedge clock);
      drive(0, (j + 1) < 3, 1'b0, 8'h00, 2'd0);
    end
    exp = model(17, 0, 8'hA5, 2'd0, 2);
    checks++; if (sample(0) !== exp) begin errors++; $display("FAIL abort_pre got %b exp %b", sample(0), exp); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (sample(0) !== 6'b100000) begin errors++; $display("FAIL abort_next got %b exp %b", sample(0), 6'b100000); end
    reset = 1'b1;
    idle(4);
    set_trig(0, 3, -1, -1, -1, -1);
    capture(0, 46, -1, 8'h00, 2'd0);
    for (int j = 0; j < 46; j++) begin
      exp = model(j, 0, 8'h00, 2'd0, 2);
      checks++;
      if (cap[j] !== exp) begin errors++; $display("FAIL abort_zero j=%0d got %b exp %b", j, cap[j], exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p;
    logic [5:0] exp;
    int dn;
    p = 8'($urandom);
    idle(4);
    load_word(p);
    set_trig(0, 3, 41, 43, 45, 48);
    capture(0, 95, -1, 8'h00, 2'd0);
    dn = 0;
    for (int j = 0; j < 95; j++) begin
      exp = (j < 45) ? model(j, 0, p, 2'd0, 2) : model(j, 45, p, 2'd0, 2);
      dn += int'(cap[j][3]);
      checks++;
      if (cap[j] !== exp) begin errors++; $display("FAIL b2b j=%0d got %b exp %b", j, cap[j], exp); end
    end
    checks++; if (dn !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", dn); end
    checks++;
    if ({cap[55][2], cap[56][2], cap[57][2]} !== 3'b001) begin
      errors++; $display("FAIL b2b_sclk_restart got %b exp 001", {cap[55][2], cap[56][2], cap[57][2]});
    end
  endtask

  task automatic test_carrier();
    logic [5:0] exp;
    logic ok;
    idle(4);
    set_trig(0, 3, -1, -1, -1, -1);
    capture(1, 46, -1, 8'h00, 2'd2);
    for (int j = 0; j < 46; j++) begin
      exp = model(j, 0, 8'h00, 2'd2, 1);
      checks++;
      if (cap[j] !== exp) begin errors++; $display("FAIL carrier j=%0d got %b exp %b", j, cap[j], exp); end
    end
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0 && cap[10 + i][2] === cap[9 + i][2]) ok = 1'b0;
      if (cap[10 + i][0] !== cap[10 + i][2] || cap[10 + i][1] !== 1'b0) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL carrier_toggle got %b exp 1", ok); end
  endtask

  initial begin
    reset = 1'b0;
    set_trig(-1, -1, -1, -1, -1, -1);
    test_reset();
    test_phase_flip();
    test_ook();
    test_random();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    test_carrier();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hh_tag_modulator.md
# hh_tag_modulator

Parametrised backscatter tag modulator, successor to the fixed-rate tag datapath. An envelope-detector trigger starts the packet. The block waits a programmable preamble interval, then drives the RF switch with a gated frequency-shift square wave modulated by a latched payload word. Modulation is phase-flip (codeword translation), on-off keying, or bare carrier. The block sits between the trigger comparator input and the RF switch pin, and is fed payload words by the tag controller.

## Interface
- SHIFT_DIV, 2: SEND cycles per half-period of the shift clock (≥1).
- BIT_CYCLES, 10: SEND cycles per payload bit, which sets the data rate (≥1).
- PREAMBLE_CYCLES, 20: WAIT cycles between trigger detection and the first modulated cycle (≥1).
- PAYLOAD_BITS, 16: payload word width (≥1).

- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- trigger_signal  in  1  asynchronous envelope-detector output; a rising edge starts a packet.
- mode  in  2  0 = phase-flip, 1 = OOK, 2/3 = carrier only; latched when WAIT is entered.
- payload  in  PAYLOAD_BITS  payload word; transmitted MSB first.
- load_valid  in  1  payload is offered this cycle.
- load_ready  out  1  high when state is IDLE.
- clock_out  out  1  gated shift clock; 0 outside SEND.
- output_signal  out  1  current payload bit; 0 outside SEND.
- signal_into_switch  out  1  RF switch drive; 0 outside SEND.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse while in DONE.

## Operation
- Reset (reset==0 at an edge) clears the following:
  - state → IDLE;
  - payload register and latched mode → 0;
  - trigger synchroniser → 0;
  - all outputs → 0, except load_ready → 1 from the first post-reset cycle.
- Trigger path: two-flop synchroniser plus one delay flop; rise = sync2 & ~sync3. A rise is acted on only in IDLE. Rises in WAIT, SEND or DONE are discarded, not queued. A trigger held high yields exactly one packet.
- Payload handshake: the transfer happens on an edge where load_valid & load_ready.
  - If the transfer and a rise occur on the same edge, the new word is used for that packet.
  - If no word was loaded, the last word is reused (0 after reset).
  - load_valid while busy has no effect.
- FSM:
  - IDLE → WAIT on rise; mode is latched on that edge.
  - WAIT → SEND after PREAMBLE_CYCLES cycles.
  - SEND → DONE after PAYLOAD_BITS*BIT_CYCLES cycles.
  - DONE → IDLE after 1 cycle.
- SEND cycle i (i = 0 at SEND entry):
  - sclk = floor(i/SHIFT_DIV) mod 2; it starts at 0 on every packet.
  - bit = payload[PAYLOAD_BITS-1-floor(i/BIT_CYCLES)].
  - clock_out = sclk; output_signal = bit.
  - signal_into_switch by mode: mode 0 → sclk ^ bit; mode 1 → sclk & bit; mode 2/3 → sclk.
- Counter widths: sized by $clog2 of each parameter-derived maximum. Counters must not wrap within a packet; all of them clear on SEND entry.

## Timing
- Let edge k be the first edge at which trigger_signal is sampled high.
  - sync2 = 1 after edge k+1.
  - state = WAIT after edge k+2; busy = 1 and load_ready = 0 from then.
  - SEND after edge k+2+PREAMBLE_CYCLES.
  - DONE after edge k+2+PREAMBLE_CYCLES+PAYLOAD_BITS*BIT_CYCLES.
  - IDLE one edge later.
- All outputs are registered and change only on clock edges. They reflect the cycle index i with no further latency.
- trigger_signal must be high for at least one sampling edge. Narrower pulses may be missed; this is not an error.
- Reset mid-packet aborts immediately: on the next edge all outputs are at reset values, with no done pulse.
- Minimum spacing between packets: one IDLE cycle after DONE before a new rise is accepted.

## Test plan
- Phase-flip timing. Setup: SHIFT_DIV=2, BIT_CYCLES=4, PREAMBLE_CYCLES=8, PAYLOAD_BITS=8; payload 8'hA5, mode 0; trigger rises at edge k.
  - Required: SEND spans edges k+10..k+42.
  - signal_into_switch in SEND cycles 0–3 = 1,1,0,0; output_signal bit sequence = 1,0,1,0,0,1,0,1.
  - done is high for exactly one cycle after edge k+42.
- OOK. Same setup, payload 8'h0F, mode 1.
  - Required: signal_into_switch = 0 for SEND cycles 0–15, then equal to clock_out for cycles 16–31.
- Carrier with fastest shift clock. SHIFT_DIV=1, mode 2, payload 0.
  - Required: clock_out toggles every cycle in SEND; signal_into_switch == clock_out throughout; output_signal = 0.
- Ignored inputs while busy. Hold trigger high for 100 cycles, add a second rise mid-SEND, and pulse load_valid with 8'hFF during WAIT.
  - Required: exactly one packet and one done pulse; the payload transmitted is still 8'hA5.
- Reset abort. Drive reset=0 at SEND cycle 7.
  - Required: the next edge gives clock_out, signal_into_switch, output_signal, busy and done = 0, and load_ready = 1.
  - The next trigger sends payload 0.
- Back-to-back packets. A new rise arrives during DONE and is ignored; another rise two cycles after IDLE starts a full packet.
  - Required: sclk restarts at 0 in that packet.
